// File: rtl/hack_mem_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | hack_mem_arbiter_pkg : shared state/owner/address constants        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package hack_mem_arbiter_pkg;

    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_SERVE    = 2'd1;
    localparam logic [1:0]  ST_RESP     = 2'd2;

    localparam logic        OWN_CPU     = 1'b0;
    localparam logic        OWN_DMA     = 1'b1;

    localparam logic [14:0] SCREEN_BASE = 15'h4000;
    localparam logic [14:0] KBD_ADDR    = 15'h6000;

    // Anything above the keyboard is unmapped; the keyboard itself is read-only.
    function automatic logic addr_rejected(input logic we, input logic [14:0] addr);
        return (addr > KBD_ADDR) || (we && (addr == KBD_ADDR));
    endfunction

endpackage

`default_nettype wire

// File: rtl/hack_mem_arbiter_starve.sv
// +--------------------------------------------------------------------+
// | arb_starve_counter : saturating count of DMA arbitration losses    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module arb_starve_counter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic limit_hit
);

    localparam int             CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] c_limit = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign limit_hit = (r_count == c_limit);

endmodule

`default_nettype wire

// File: rtl/hack_mem_arbiter.sv
// +--------------------------------------------------------------------+
// | hack_mem_arbiter : CPU/DMA arbiter for the Hack data memory port   |
// | Optional address guard: HACK_MEM_ARB_ADDR_GUARD_EN      Rev 1.0    |
// +--------------------------------------------------------------------+
`default_nettype none

module hack_mem_arbiter
    import hack_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [14:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_ack,
    output logic [15:0] dma_rdata,
    output logic [15:0] mem_in,
    output logic [14:0] mem_address,
    output logic        mem_load,
    input  logic [15:0] mem_out,
    output logic        addr_err
);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;

    logic        r_owner;
    logic        r_we;
    logic [14:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_reject;
    logic [15:0] r_cpu_rdata;
    logic [15:0] r_dma_rdata;

    logic        w_any_req;
    logic        w_limit_hit;
    logic        w_grant_dma;
    logic        w_sel_we;
    logic [14:0] w_sel_addr;
    logic [15:0] w_sel_wdata;
    logic        w_req_reject;
    logic        w_starve_inc;
    logic        w_starve_clr;
    logic        w_idle;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_any_req   = cpu_req | dma_req;
    // CPU has fixed priority until DMA has lost STARVE_LIMIT times in a row.
    assign w_grant_dma = dma_req & (~cpu_req | w_limit_hit);
    assign w_sel_we    = w_grant_dma ? dma_we    : cpu_we;
    assign w_sel_addr  = w_grant_dma ? dma_addr  : cpu_addr;
    assign w_sel_wdata = w_grant_dma ? dma_wdata : cpu_wdata;

`ifdef HACK_MEM_ARB_ADDR_GUARD_EN
    assign w_req_reject = addr_rejected(w_sel_we, w_sel_addr);
`else
    assign w_req_reject = 1'b0;
`endif

    assign w_starve_inc = w_idle & dma_req & ~w_grant_dma;
    assign w_starve_clr = w_idle & (~dma_req | w_grant_dma);

    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (w_starve_inc),
        .clr       (w_starve_clr),
        .limit_hit (w_limit_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_req) w_next_state = ST_SERVE;
            ST_SERVE: w_next_state = ST_RESP;
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Request fields are frozen at the IDLE exit; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner  <= OWN_CPU;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_reject <= 1'b0;
        end else if (w_idle && w_any_req) begin
            r_owner  <= w_grant_dma ? OWN_DMA : OWN_CPU;
            r_we     <= w_sel_we;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_reject <= w_req_reject;
        end
    end

    // Writes keep rdata; reads and rejected accesses replace it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else if ((r_state == ST_SERVE) && (r_reject || !r_we)) begin
            if (r_owner == OWN_DMA) begin
                r_dma_rdata <= r_reject ? 16'h0000 : mem_out;
            end else begin
                r_cpu_rdata <= r_reject ? 16'h0000 : mem_out;
            end
        end
    end

    always_comb begin
        mem_address = '0;
        mem_in      = '0;
        mem_load    = 1'b0;
        cpu_ack     = 1'b0;
        dma_ack     = 1'b0;
        addr_err    = 1'b0;
        case (r_state)
            ST_SERVE: begin
                mem_address = r_addr;
                mem_in      = r_wdata;
                mem_load    = r_we & ~r_reject;
            end
            ST_RESP: begin
                cpu_ack  = (r_owner == OWN_CPU);
                dma_ack  = (r_owner == OWN_DMA);
                addr_err = r_reject;
            end
            default: ;
        endcase
    end

    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;

endmodule

`default_nettype wire

// File: tb/tb_hack_mem_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_hack_mem_arbiter : directed self-checking bench for the arbiter |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_hack_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_ack;
    logic [14:0] dma_addr;
    logic [15:0] dma_wdata, dma_rdata;
    logic [15:0] mem_in, mem_out;
    logic [14:0] mem_address;
    logic        mem_load;
    logic        addr_err;

    logic        tb_wr;
    logic [14:0] tb_waddr;
    logic [15:0] tb_wdata;
    logic [15:0] mem [0:32767];

    int checks;
    int failures;

    hack_mem_arbiter #(
        .STARVE_LIMIT (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_ack     (dma_ack),
        .dma_rdata   (dma_rdata),
        .mem_in      (mem_in),
        .mem_address (mem_address),
        .mem_load    (mem_load),
        .mem_out     (mem_out),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_load) mem[mem_address] <= mem_in;
        if (tb_wr)    mem[tb_waddr]    <= tb_wdata;
    end
    assign mem_out = mem[mem_address];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [14:0] a, input logic [15:0] d);
        tb_wr = 1'b1; tb_waddr = a; tb_wdata = d;
        tick();
        tb_wr = 1'b0;
    endtask

    bit [5:0] order;

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        tb_wr = 0; tb_waddr = '0; tb_wdata = '0;

        preload(15'h0020, 16'h1234);
        preload(15'h0100, 16'hC0C0);
        preload(15'h0200, 16'hD0D0);
        preload(15'h6000, 16'h0041);
        preload(15'h4000, 16'h5555);
        preload(15'h7000, 16'h7777);

        chk("rst_cpu_ack",   16'(cpu_ack),     16'h0);
        chk("rst_dma_ack",   16'(dma_ack),     16'h0);
        chk("rst_cpu_rdata", cpu_rdata,        16'h0);
        chk("rst_dma_rdata", dma_rdata,        16'h0);
        chk("rst_mem_load",  16'(mem_load),    16'h0);
        chk("rst_mem_addr",  16'(mem_address), 16'h0);
        chk("rst_mem_in",    mem_in,           16'h0);
        chk("rst_addr_err",  16'(addr_err),    16'h0);
        rst_n = 1'b1;
        tick();

        // CPU write BEEF -> 0010
        cpu_req = 1; cpu_we = 1; cpu_addr = 15'h0010; cpu_wdata = 16'hBEEF;
        tick();
        chk("wr_serve_load", 16'(mem_load),    16'h1);
        chk("wr_serve_addr", 16'(mem_address), 16'h0010);
        chk("wr_serve_in",   mem_in,           16'hBEEF);
        chk("wr_serve_ack",  16'(cpu_ack),     16'h0);
        tick();
        chk("wr_resp_ack",   16'(cpu_ack),     16'h1);
        chk("wr_resp_dack",  16'(dma_ack),     16'h0);
        chk("wr_resp_load",  16'(mem_load),    16'h0);
        chk("wr_resp_addr",  16'(mem_address), 16'h0);
        chk("wr_resp_err",   16'(addr_err),    16'h0);
        chk("wr_mem",        mem[15'h0010],    16'hBEEF);
        cpu_req = 0;
        tick();
        chk("wr_idle_ack",   16'(cpu_ack),     16'h0);

        // CPU read 0010, address input changes during SERVE
        cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0010; cpu_wdata = 16'h0;
        tick();
        chk("rd_serve_load", 16'(mem_load),    16'h0);
        chk("rd_serve_addr", 16'(mem_address), 16'h0010);
        cpu_addr = 15'h0020;
        #2;
        chk("rd_serve_hold", 16'(mem_address), 16'h0010);
        tick();
        chk("rd_resp_ack",   16'(cpu_ack),     16'h1);
        chk("rd_resp_dack",  16'(dma_ack),     16'h0);
        chk("rd_resp_data",  cpu_rdata,        16'hBEEF);
        cpu_req = 0;
        tick();
        chk("rd_idle_ack",   16'(cpu_ack),     16'h0);
        chk("rd_idle_hold",  cpu_rdata,        16'hBEEF);

        // DMA read of keyboard
        dma_req = 1; dma_we = 0; dma_addr = 15'h6000;
        tick();
        chk("kbd_serve_load", 16'(mem_load),    16'h0);
        chk("kbd_serve_addr", 16'(mem_address), 16'h6000);
        tick();
        chk("kbd_resp_dack", 16'(dma_ack),     16'h1);
        chk("kbd_resp_cack", 16'(cpu_ack),     16'h0);
        chk("kbd_resp_data", dma_rdata,        16'h0041);
        chk("kbd_resp_load", 16'(mem_load),    16'h0);
        chk("kbd_resp_err",  16'(addr_err),    16'h0);
        dma_req = 0;
        tick();

        // Both requesting continuously, STARVE_LIMIT=2: C C D C C D
        order = 6'b100100;
        cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0100;
        dma_req = 1; dma_we = 0; dma_addr = 15'h0200;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("starve_addr%0d", i), 16'(mem_address), order[i] ? 16'h0200 : 16'h0100);
            tick();
            chk($sformatf("starve_cack%0d", i), 16'(cpu_ack), order[i] ? 16'h0 : 16'h1);
            chk($sformatf("starve_dack%0d", i), 16'(dma_ack), order[i] ? 16'h1 : 16'h0);
            tick();
        end
        chk("starve_crdata", cpu_rdata, 16'hC0C0);
        chk("starve_drdata", dma_rdata, 16'hD0D0);
        cpu_req = 0; dma_req = 0;
        tick();

        // Reset during SERVE of a CPU write to 4000
        cpu_req = 1; cpu_we = 1; cpu_addr = 15'h4000; cpu_wdata = 16'hAAAA;
        tick();
        chk("abort_serve_load", 16'(mem_load), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_load_drop", 16'(mem_load),    16'h0);
        chk("abort_addr_drop", 16'(mem_address), 16'h0);
        chk("abort_in_drop",   mem_in,           16'h0);
        tick();
        chk("abort_no_ack",    16'(cpu_ack),     16'h0);
        cpu_req = 0;
        rst_n = 1'b1;
        tick();
        chk("abort_post_ack",   16'(cpu_ack),     16'h0);
        chk("abort_post_dack",  16'(dma_ack),     16'h0);
        chk("abort_post_load",  16'(mem_load),    16'h0);
        chk("abort_post_addr",  16'(mem_address), 16'h0);
        chk("abort_post_err",   16'(addr_err),    16'h0);
        chk("abort_post_rdata", cpu_rdata,        16'h0);
        chk("abort_mem",        mem[15'h4000],    16'h5555);
        cpu_req = 1; cpu_we = 0; cpu_addr = 15'h4000;
        tick();
        chk("abort_rd_serve", 16'(mem_address), 16'h4000);
        tick();
        chk("abort_rd_ack",   16'(cpu_ack),     16'h1);
        chk("abort_rd_data",  cpu_rdata,        16'h5555);
        cpu_req = 0;
        tick();

`ifdef HACK_MEM_ARB_ADDR_GUARD_EN
        cpu_req = 1; cpu_we = 1; cpu_addr = 15'h6000; cpu_wdata = 16'h1111;
        tick();
        chk("gw_serve_load", 16'(mem_load), 16'h0);
        tick();
        chk("gw_resp_ack",   16'(cpu_ack),  16'h1);
        chk("gw_resp_err",   16'(addr_err), 16'h1);
        chk("gw_mem",        mem[15'h6000], 16'h0041);
        cpu_req = 0;
        tick();
        chk("gw_idle_err",   16'(addr_err), 16'h0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 15'h7000;
        tick();
        chk("gr_serve_load", 16'(mem_load), 16'h0);
        tick();
        chk("gr_resp_ack",   16'(cpu_ack),  16'h1);
        chk("gr_resp_err",   16'(addr_err), 16'h1);
        chk("gr_resp_data",  cpu_rdata,     16'h0);
        cpu_req = 0;
        tick();
`else
        cpu_req = 1; cpu_we = 1; cpu_addr = 15'h6000; cpu_wdata = 16'h1111;
        tick();
        chk("nw_serve_load", 16'(mem_load), 16'h1);
        tick();
        chk("nw_resp_ack",   16'(cpu_ack),  16'h1);
        chk("nw_resp_err",   16'(addr_err), 16'h0);
        chk("nw_mem",        mem[15'h6000], 16'h1111);
        cpu_req = 0;
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 15'h7000;
        tick();
        tick();
        chk("nr_resp_ack",   16'(cpu_ack),  16'h1);
        chk("nr_resp_err",   16'(addr_err), 16'h0);
        chk("nr_resp_data",  cpu_rdata,     16'h7777);
        cpu_req = 0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
